// File: rtl/router_pkg.sv
// Shared constants for the router datapath.
package router_pkg;

  localparam int unsigned DATA_W = 8;
  localparam logic [1:0] INVALID_ADDR = 2'b11;

  function automatic logic addr_valid(input logic [DATA_W-1:0] hdr);
    return hdr[1:0] != INVALID_ADDR;
  endfunction

endpackage

// File: rtl/router_parity_check.sv
// Running XOR parity of header/payload, captured parity byte and mismatch flag.
module router_parity_check
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              detect_addr,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              full_state,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] din,
  input  logic [DATA_W-1:0] header,
  input  logic              parity_done,
  output logic              err
);

  logic [DATA_W-1:0] acc_q;
  logic [DATA_W-1:0] pkt_parity_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
    end else if (detect_addr) begin
      acc_q <= '0;
    end else if (lfd_state) begin
      acc_q <= acc_q ^ header;
    end else if (ld_state && pkt_valid && !full_state) begin
      acc_q <= acc_q ^ din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pkt_parity_q <= '0;
    end else if (detect_addr) begin
      pkt_parity_q <= '0;
    end else if (ld_state && !pkt_valid) begin
      pkt_parity_q <= din;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      err <= 1'b0;
    end else if (detect_addr) begin
      err <= 1'b0;
    end else if (parity_done) begin
      err <= acc_q != pkt_parity_q;
    end
  end

endmodule

// File: rtl/router_register.sv
// Router byte register: header/hold capture, FIFO data steering and packet-end flags.
// Parity checking is built only when ROUTER_REGISTER_PARITY_CHECK_EN is defined.
module router_register
  import router_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              pkt_valid,
  input  logic [DATA_W-1:0] din,
  input  logic              fifo_full,
  input  logic              detect_addr,
  input  logic              lfd_state,
  input  logic              ld_state,
  input  logic              laf_state,
  input  logic              full_state,
  input  logic              rst_int_reg,
  output logic [DATA_W-1:0] dout,
  output logic              err,
  output logic              parity_done,
  output logic              low_pkt_valid
);

  logic [DATA_W-1:0] header_q;
  logic [DATA_W-1:0] hold_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      header_q <= '0;
    end else if (detect_addr && pkt_valid && addr_valid(din)) begin
      header_q <= din;
    end
  end

  // Bytes arriving while the FIFO is full are parked in hold_q and replayed in laf_state.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout   <= '0;
      hold_q <= '0;
    end else if (lfd_state) begin
      dout <= header_q;
    end else if (ld_state && !fifo_full) begin
      dout <= din;
    end else if (ld_state && fifo_full) begin
      hold_q <= din;
    end else if (laf_state) begin
      dout <= hold_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      low_pkt_valid <= 1'b0;
    end else if (rst_int_reg) begin
      low_pkt_valid <= 1'b0;
    end else if (ld_state && !pkt_valid) begin
      low_pkt_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      parity_done <= 1'b0;
    end else if (detect_addr) begin
      parity_done <= 1'b0;
    end else if ((ld_state && !fifo_full && !pkt_valid) ||
                 (laf_state && low_pkt_valid && !parity_done)) begin
      parity_done <= 1'b1;
    end
  end

`ifdef ROUTER_REGISTER_PARITY_CHECK_EN
  router_parity_check u_parity_check (
    .clk         (clk),
    .rst         (rst),
    .detect_addr (detect_addr),
    .lfd_state   (lfd_state),
    .ld_state    (ld_state),
    .full_state  (full_state),
    .pkt_valid   (pkt_valid),
    .din         (din),
    .header      (header_q),
    .parity_done (parity_done),
    .err         (err)
  );
`else
  logic unused_full_state;
  assign unused_full_state = full_state;
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_router_register.sv
// Directed self-checking bench for router_register.
module tb_router_register;
  import router_pkg::*;

`ifdef ROUTER_REGISTER_PARITY_CHECK_EN
  localparam bit ParEn = 1'b1;
`else
  localparam bit ParEn = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              pkt_valid;
  logic [DATA_W-1:0] din;
  logic              fifo_full;
  logic              detect_addr, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
  logic [DATA_W-1:0] dout;
  logic              err, parity_done, low_pkt_valid;

  int total = 0;
  int bad = 0;

  logic [7:0] payload [8];
  logic [7:0] good_par;

  router_register dut (
    .clk           (clk),
    .rst           (rst),
    .pkt_valid     (pkt_valid),
    .din           (din),
    .fifo_full     (fifo_full),
    .detect_addr   (detect_addr),
    .lfd_state     (lfd_state),
    .ld_state      (ld_state),
    .laf_state     (laf_state),
    .full_state    (full_state),
    .rst_int_reg   (rst_int_reg),
    .dout          (dout),
    .err           (err),
    .parity_done   (parity_done),
    .low_pkt_valid (low_pkt_valid)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_dout"}, dout, 8'h00);
    chk({tag, "_err"}, {7'd0, err}, 8'h00);
    chk({tag, "_pdone"}, {7'd0, parity_done}, 8'h00);
    chk({tag, "_lpv"}, {7'd0, low_pkt_valid}, 8'h00);
  endtask

  task automatic clear_strobes();
    detect_addr = 0; lfd_state = 0; ld_state = 0; laf_state = 0;
    full_state = 0; rst_int_reg = 0; fifo_full = 0;
  endtask

  task automatic send_packet(input logic [7:0] par, input logic exp_err, input string tag);
    clear_strobes();
    detect_addr = 1; pkt_valid = 1; din = 8'h15;
    step();
    detect_addr = 0; lfd_state = 1; din = 8'h00;
    step();
    chk({tag, "_hdr_dout"}, dout, 8'h15);
    lfd_state = 0; ld_state = 1;
    for (int i = 0; i < 8; i++) begin
      din = payload[i];
      step();
      chk($sformatf("%s_pl%0d", tag, i), dout, payload[i]);
    end
    pkt_valid = 0; din = par;
    step();
    chk({tag, "_lpv"}, {7'd0, low_pkt_valid}, 8'h01);
    chk({tag, "_pdone"}, {7'd0, parity_done}, 8'h01);
    ld_state = 0; din = 8'h00;
    step();
    chk({tag, "_err"}, {7'd0, err}, {7'd0, exp_err});
  endtask

  initial begin
    payload[0] = 8'hC3; payload[1] = 8'h5A; payload[2] = 8'h01; payload[3] = 8'h7E;
    payload[4] = 8'h99; payload[5] = 8'h24; payload[6] = 8'hF0; payload[7] = 8'h0F;
    good_par = 8'h15;
    for (int i = 0; i < 8; i++) good_par = good_par ^ payload[i];

    rst = 0; pkt_valid = 0; din = 8'h00;
    clear_strobes();
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1 rst = 1;

    // Good packet, then a corrupted parity byte.
    send_packet(good_par, 1'b0, "good");
    send_packet(8'd46, ParEn, "badpar");

    // rst_int_reg clears low_pkt_valid only; detect_addr clears the rest.
    rst_int_reg = 1;
    step();
    chk("rstint_lpv", {7'd0, low_pkt_valid}, 8'h00);
    chk("rstint_pdone_hold", {7'd0, parity_done}, 8'h01);
    chk("rstint_err_hold", {7'd0, err}, {7'd0, ParEn});
    rst_int_reg = 0; detect_addr = 1; pkt_valid = 1; din = 8'h15;
    step();
    chk("detect_pdone", {7'd0, parity_done}, 8'h00);
    chk("detect_err", {7'd0, err}, 8'h00);
    detect_addr = 0;

    // Invalid address after reset leaves header at 0.
    #2 rst = 0;
    #1 chk_all_zero("rst2");
    @(posedge clk); #1 rst = 1;
    detect_addr = 1; pkt_valid = 1; din = 8'h17;
    step();
    detect_addr = 0; lfd_state = 1; din = 8'h00;
    step();
    chk("badaddr_dout", dout, 8'h00);

    // FIFO full: byte is held, replayed in laf_state.
    lfd_state = 0; ld_state = 1; fifo_full = 1; pkt_valid = 1; din = 8'hA5;
    step();
    chk("full_dout_hold", dout, 8'h00);
    ld_state = 0; fifo_full = 0; laf_state = 1; din = 8'h00;
    step();
    chk("laf_dout", dout, 8'hA5);

    // Parity byte arrives while full: parity_done comes via laf path.
    laf_state = 0; ld_state = 1; fifo_full = 1; pkt_valid = 0; din = 8'h3C;
    step();
    chk("fullpar_lpv", {7'd0, low_pkt_valid}, 8'h01);
    chk("fullpar_pdone", {7'd0, parity_done}, 8'h00);
    ld_state = 0; fifo_full = 0; laf_state = 1; din = 8'h00;
    step();
    chk("lafpar_pdone", {7'd0, parity_done}, 8'h01);
    chk("lafpar_dout", dout, 8'h3C);
    laf_state = 0;

    // Mid-packet asynchronous reset.
    rst_int_reg = 1;
    step();
    rst_int_reg = 0; detect_addr = 1; pkt_valid = 1; din = 8'h15;
    step();
    detect_addr = 0; lfd_state = 1;
    step();
    lfd_state = 0; ld_state = 1; din = 8'h66;
    step();
    chk("mid_dout", dout, 8'h66);
    #2 rst = 0;
    #1 chk_all_zero("midrst");
    clear_strobes();
    @(posedge clk); #1 rst = 1;
    lfd_state = 1;
    step();
    chk("midrst_hdr_gone", dout, 8'h00);
    lfd_state = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
